// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns 6-byte UART command packets (A5 CMD X Y COLOR CSUM)
// into framebuffer write transactions: single-pixel write or full-screen fill.
module uart_cmd_parser #(
  parameter int unsigned H_RES          = 160,
  parameter int unsigned V_RES          = 120,
  parameter int unsigned ADDR_BITS      = 15,
  parameter int unsigned COLOR_BITS     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 250000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  fb_we,
  output logic [ADDR_BITS-1:0]  fb_addr,
  output logic [COLOR_BITS-1:0] fb_data,
  input  logic                  fb_ready,
  output logic                  cmd_done,
  output logic                  cmd_err,
  output logic                  overrun
);

  localparam int unsigned TO_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned PIX_TOTAL = H_RES * V_RES;

  localparam logic [7:0]           SYNC_BYTE = 8'hA5;
  localparam logic [7:0]           OP_PIXEL  = 8'h01;
  localparam logic [7:0]           OP_FILL   = 8'h02;
  localparam logic [TO_W-1:0]      TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(PIX_TOTAL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_X,
    S_Y,
    S_COLOR,
    S_CSUM,
    S_WRITE,
    S_FILL
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [7:0]           x_q, x_d;
  logic [7:0]           y_q, y_d;
  logic [7:0]           color_q, color_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 fb_we_d;
  logic [ADDR_BITS-1:0] fb_addr_d;
  logic [COLOR_BITS-1:0] fb_data_d;
  logic                 cmd_done_d;
  logic                 cmd_err_d;
  logic                 overrun_d;

  logic                 csum_ok_c;
  logic                 opcode_ok_c;
  logic                 in_range_c;
  logic                 timed_out_c;
  logic                 handshake_c;
  logic [ADDR_BITS-1:0] pix_addr_c;

  // Packet checks and pixel address derived from the latched header bytes
  assign csum_ok_c   = ((cmd_q ^ x_q ^ y_q ^ color_q) == rx_data);
  assign opcode_ok_c = (cmd_q == OP_PIXEL) || (cmd_q == OP_FILL);
  assign in_range_c  = (32'(x_q) < H_RES) && (32'(y_q) < V_RES);
  assign timed_out_c = (to_cnt_q == TO_LAST);
  assign handshake_c = fb_we && fb_ready;
  assign pix_addr_c  = ADDR_BITS'(y_q) * ADDR_BITS'(H_RES) + ADDR_BITS'(x_q);

  // State, latched bytes, timeout counter and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      color_q  <= '0;
      to_cnt_q <= '0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      x_q      <= x_d;
      y_q      <= y_d;
      color_q  <= color_d;
      to_cnt_q <= to_cnt_d;
      fb_we    <= fb_we_d;
      fb_addr  <= fb_addr_d;
      fb_data  <= fb_data_d;
      cmd_done <= cmd_done_d;
      cmd_err  <= cmd_err_d;
      overrun  <= overrun_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    x_d        = x_q;
    y_d        = y_q;
    color_d    = color_q;
    to_cnt_d   = '0;
    fb_we_d    = fb_we;
    fb_addr_d  = fb_addr;
    fb_data_d  = fb_data;
    cmd_done_d = 1'b0;
    cmd_err_d  = 1'b0;
    overrun_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Non-sync bytes are dropped silently while hunting for a packet
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = S_CMD;
        end
      end

      S_CMD, S_X, S_Y, S_COLOR, S_CSUM: begin
        if (rx_valid) begin
          // A byte on the timeout cycle takes precedence over the timeout
          case (state_q)
            S_CMD: begin
              cmd_d   = rx_data;
              state_d = S_X;
            end
            S_X: begin
              x_d     = rx_data;
              state_d = S_Y;
            end
            S_Y: begin
              y_d     = rx_data;
              state_d = S_COLOR;
            end
            S_COLOR: begin
              color_d = rx_data;
              state_d = S_CSUM;
            end
            default: begin
              // Checksum first, then opcode, then pixel range
              if (!csum_ok_c || !opcode_ok_c ||
                  ((cmd_q == OP_PIXEL) && !in_range_c)) begin
                cmd_err_d = 1'b1;
                state_d   = S_IDLE;
              end else if (cmd_q == OP_PIXEL) begin
                fb_we_d   = 1'b1;
                fb_addr_d = pix_addr_c;
                fb_data_d = COLOR_BITS'(color_q);
                state_d   = S_WRITE;
              end else begin
                fb_we_d   = 1'b1;
                fb_addr_d = '0;
                fb_data_d = COLOR_BITS'(color_q);
                state_d   = S_FILL;
              end
            end
          endcase
        end else if (timed_out_c) begin
          cmd_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_WRITE: begin
        // No byte buffering while a write is in flight
        overrun_d = rx_valid;
        if (handshake_c) begin
          fb_we_d    = 1'b0;
          cmd_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end

      S_FILL: begin
        overrun_d = rx_valid;
        if (handshake_c) begin
          if (fb_addr == LAST_ADDR) begin
            fb_we_d    = 1'b0;
            fb_addr_d  = '0;
            cmd_done_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            fb_addr_d = fb_addr + ADDR_BITS'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: table vectors, directed corner sequences and random
// packets checked against a packet-level reference model.
module tb_uart_cmd_parser;

  localparam int unsigned H_RES  = 160;
  localparam int unsigned V_RES  = 120;
  localparam int unsigned AB     = 15;
  localparam int unsigned CB     = 8;
  localparam int unsigned TO     = 100;
  localparam int          NPIX   = 19200;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          fb_we;
  logic [AB-1:0] fb_addr;
  logic [CB-1:0] fb_data;
  logic          fb_ready = 1'b0;
  logic          cmd_done;
  logic          cmd_err;
  logic          overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_mode = 0;   // 0: always ready, 1: toggle, 2: random

  uart_cmd_parser #(
    .H_RES(H_RES), .V_RES(V_RES), .ADDR_BITS(AB), .COLOR_BITS(CB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
    .cmd_done(cmd_done), .cmd_err(cmd_err), .overrun(overrun)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #3ms;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  // Backpressure generator
  initial forever begin
    @(posedge clock);
    #1;
    case (ready_mode)
      0:       fb_ready = 1'b1;
      1:       fb_ready = ~fb_ready;
      default: fb_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Observation monitor: records handshakes, pulses and protocol violations
  int unsigned cyc = 0;
  int done_total = 0, err_total = 0, ovr_total = 0;
  int stall_viol = 0, dbl_pulse = 0;
  int last_hs_cyc = 0, last_done_cyc = 0;
  int hs_addr_q[$];
  int hs_data_q[$];
  logic          p_we = 1'b0, p_rdy = 1'b0, p_rst = 1'b1;
  logic          p_done = 1'b0, p_err = 1'b0, p_ovr = 1'b0;
  logic [AB-1:0] p_addr = '0;
  logic [CB-1:0] p_data = '0;

  initial forever begin
    @(negedge clock);
    cyc++;
    if (!reset) begin
      if (fb_we && fb_ready) begin
        hs_addr_q.push_back(int'(fb_addr));
        hs_data_q.push_back(int'(fb_data));
        last_hs_cyc = cyc;
      end
      if (p_we && !p_rdy && !p_rst &&
          (!fb_we || fb_addr != p_addr || fb_data != p_data)) stall_viol++;
      if (cmd_done) begin
        done_total++;
        last_done_cyc = cyc;
        if (p_done) dbl_pulse++;
      end
      if (cmd_err) begin
        err_total++;
        if (p_err) dbl_pulse++;
      end
      if (overrun) begin
        ovr_total++;
        if (p_ovr) dbl_pulse++;
      end
    end
    p_we = fb_we; p_rdy = fb_ready; p_rst = reset;
    p_addr = fb_addr; p_data = fb_data;
    p_done = cmd_done; p_err = cmd_err; p_ovr = overrun;
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Packet-level reference: what a 6-byte packet must produce
  function automatic void ref_model(input logic [47:0] pkt, output bit err,
                                    output int addr, output int data);
    int c, x, y, col, cs;
    c   = int'(pkt[39:32]);
    x   = int'(pkt[31:24]);
    y   = int'(pkt[23:16]);
    col = int'(pkt[15:8]);
    cs  = int'(pkt[7:0]);
    err = ((c ^ x ^ y ^ col) != cs) || !(c == 1 || c == 2) ||
          (c == 1 && (x >= int'(H_RES) || y >= int'(V_RES)));
    addr = y * int'(H_RES) + x;
    data = col % (1 << CB);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clock);
    @(posedge clock);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic wait_evt(input int bd, input int be, input int bound, input string nm);
    int k = 0;
    while (done_total == bd && err_total == be && k < bound) begin
      @(negedge clock);
      k++;
    end
    chk({nm, "_finished"}, (done_total != bd || err_total != be) ? 1 : 0, 1);
  endtask

  // Send one packet (optionally preceded by junk bytes) and check its outcome
  task automatic run_pkt(input logic [47:0] pkt, input int ngarb, input int gap_max,
                         input int long_idx, input int long_gap, input bit exp_err,
                         input int exp_addr, input int exp_data, input string nm);
    int bd, be, bh, bs, bdl, bo, g;
    logic [7:0] junk;
    bd = done_total; be = err_total; bh = hs_addr_q.size();
    bs = stall_viol; bdl = dbl_pulse; bo = ovr_total;
    for (int i = 0; i < ngarb; i++) begin
      junk = 8'($urandom_range(0, 255));
      if (junk == 8'hA5) junk = 8'h00;
      send_byte(junk, $urandom_range(0, gap_max));
    end
    for (int i = 0; i < 6; i++) begin
      g = (i == long_idx) ? long_gap : $urandom_range(0, gap_max);
      send_byte(pkt[47-8*i -: 8], g);
    end
    wait_evt(bd, be, 2000, nm);
    repeat (3) @(negedge clock);
    chk({nm, "_err"},    err_total - be, exp_err ? 1 : 0);
    chk({nm, "_done"},   done_total - bd, exp_err ? 0 : 1);
    chk({nm, "_writes"}, hs_addr_q.size() - bh, exp_err ? 0 : 1);
    if (!exp_err && hs_addr_q.size() == bh + 1) begin
      chk({nm, "_addr"}, hs_addr_q[bh], exp_addr);
      chk({nm, "_data"}, hs_data_q[bh], exp_data);
      chk({nm, "_done_lat"}, last_done_cyc - last_hs_cyc, 1);
    end
    chk({nm, "_stall"},   stall_viol - bs, 0);
    chk({nm, "_dbl"},     dbl_pulse - bdl, 0);
    chk({nm, "_overrun"}, ovr_total - bo, 0);
  endtask

  typedef struct {
    logic [47:0] pkt;
    int          rdy;
    bit          err;
    int          addr;
    int          data;
    string       name;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int bd, be, bh, bs, bdl, bo, k, bad, we_seen;
    logic [47:0] rp;
    bit e;
    int a, d;

    vecs[0] = '{48'hA5_01_03_02_1C_1C, 0, 1'b0, 323,   8'h1C, "pixel"};
    vecs[1] = '{48'hA5_01_03_02_1C_1D, 0, 1'b1, 0,     0,     "bad_csum"};
    vecs[2] = '{48'hA5_01_03_02_1C_1C, 1, 1'b0, 323,   8'h1C, "after_err"};
    vecs[3] = '{48'hA5_01_A0_00_FF_5E, 0, 1'b1, 0,     0,     "x_range"};
    vecs[4] = '{48'hA5_07_00_00_00_07, 0, 1'b1, 0,     0,     "bad_op"};
    vecs[5] = '{48'hA5_01_00_78_11_68, 2, 1'b1, 0,     0,     "y_range"};
    vecs[6] = '{48'hA5_01_9F_77_A5_4C, 1, 1'b0, 19199, 8'hA5, "corner"};
    vecs[7] = '{48'hA5_01_00_00_00_01, 2, 1'b0, 0,     8'h00, "origin"};
    vecs[8] = '{48'hA5_00_05_05_00_00, 2, 1'b1, 0,     0,     "op_zero"};

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_fb_we",    int'(fb_we), 0);
    chk("rst_fb_addr",  int'(fb_addr), 0);
    chk("rst_fb_data",  int'(fb_data), 0);
    chk("rst_cmd_done", int'(cmd_done), 0);
    chk("rst_cmd_err",  int'(cmd_err), 0);
    chk("rst_overrun",  int'(overrun), 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      ready_mode = vecs[i].rdy;
      run_pkt(vecs[i].pkt, 0, 2, -1, 0, vecs[i].err, vecs[i].addr, vecs[i].data, vecs[i].name);
    end

    // Byte arriving on the last timeout cycle wins
    ready_mode = 0;
    run_pkt(48'hA5_01_03_02_1C_1C, 0, 0, 2, 98, 1'b0, 323, 8'h1C, "to_edge");

    // Timeout after A5 01 then silence
    be = err_total; bh = hs_addr_q.size();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    k = 0; we_seen = 0;
    while (k < 300) begin
      @(posedge clock);
      #1;
      k++;
      if (fb_we) we_seen = 1;
      if (cmd_err) break;
    end
    chk("timeout_cycles", k, int'(TO));
    repeat (3) @(negedge clock);
    chk("timeout_err_cnt", err_total - be, 1);
    chk("timeout_no_we", we_seen, 0);
    chk("timeout_no_write", hs_addr_q.size() - bh, 0);
    run_pkt(48'hA5_01_0A_05_3C_32, 0, 1, -1, 0, 1'b0, 810, 8'h3C, "after_to");

    // Fill with toggling backpressure and an overrun byte mid-fill
    ready_mode = 1;
    bd = done_total; be = err_total; bh = hs_addr_q.size();
    bs = stall_viol; bdl = dbl_pulse; bo = ovr_total;
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'hE0, 0); send_byte(8'hE2, 0);
    repeat (2000) @(negedge clock);
    send_byte(8'h33, 0);
    wait_evt(bd, be, 60000, "fill");
    repeat (3) @(negedge clock);
    chk("fill_count", hs_addr_q.size() - bh, NPIX);
    bad = 0;
    if (hs_addr_q.size() - bh == NPIX) begin
      for (int i = 0; i < NPIX; i++)
        if (hs_addr_q[bh+i] != i || hs_data_q[bh+i] != 8'hE0) bad++;
    end else begin
      bad = -1;
    end
    chk("fill_order", bad, 0);
    chk("fill_done",     done_total - bd, 1);
    chk("fill_err",      err_total - be, 0);
    chk("fill_overrun",  ovr_total - bo, 1);
    chk("fill_stall",    stall_viol - bs, 0);
    chk("fill_dbl",      dbl_pulse - bdl, 0);
    chk("fill_done_lat", last_done_cyc - last_hs_cyc, 1);
    chk("fill_end_we",   int'(fb_we), 0);
    chk("fill_end_addr", int'(fb_addr), 0);

    // Reset in the middle of a fill
    ready_mode = 0;
    bd = done_total; be = err_total;
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h05, 0);
    send_byte(8'h07, 0); send_byte(8'h3C, 0); send_byte(8'h3C, 0);
    k = 0;
    while (!(fb_we && fb_addr == AB'(500)) && k < 2000) begin
      @(negedge clock);
      k++;
    end
    chk("rstfill_reached", (fb_we && fb_addr == AB'(500)) ? 1 : 0, 1);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rstfill_we",   int'(fb_we), 0);
    chk("rstfill_addr", int'(fb_addr), 0);
    chk("rstfill_data", int'(fb_data), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("rstfill_no_done", done_total - bd, 0);
    chk("rstfill_no_err",  err_total - be, 0);
    run_pkt(48'hA5_01_03_02_1C_1C, 0, 1, -1, 0, 1'b0, 323, 8'h1C, "after_rst");

    // Random packets against the reference model
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      rp[47:40] = 8'hA5;
      rp[39:32] = 8'h01;
      if ($urandom_range(0, 9) == 0) begin
        rp[39:32] = 8'($urandom_range(0, 255));
        if (rp[39:32] == 8'h01 || rp[39:32] == 8'h02) rp[39:32] = 8'h00;
      end
      rp[31:24] = 8'($urandom_range(0, 169));
      rp[23:16] = 8'($urandom_range(0, 129));
      rp[15:8]  = 8'($urandom_range(0, 255));
      rp[7:0]   = rp[39:32] ^ rp[31:24] ^ rp[23:16] ^ rp[15:8];
      if ($urandom_range(0, 9) == 0) rp[7:0] = rp[7:0] ^ 8'(1 << $urandom_range(0, 7));
      ref_model(rp, e, a, d);
      run_pkt(rp, $urandom_range(0, 2), 4, -1, 0, e, a, d, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Consumes the byte stream produced by the UART receiver (8-bit data plus one-cycle data_ready strobe).
- Parses fixed 6-byte command packets and turns each valid packet into framebuffer write transactions for the VGA pixel memory.
- Supports a single-pixel write and a full-screen fill, with checksum, range check and inter-byte timeout.
- Sits between uart_rx and the framebuffer write port, in the 25 MHz pixel clock domain.

Parameters:
- H_RES, 160, framebuffer width in pixels.
- V_RES, 120, framebuffer height in pixels.
- ADDR_BITS, 15, framebuffer address width; must satisfy 2^ADDR_BITS >= H_RES*V_RES.
- COLOR_BITS, 8, pixel width; the colour byte's low COLOR_BITS bits are used.
- TIMEOUT_CYCLES, 250000, maximum allowed clocks between bytes of one packet (10 ms at 25 MHz).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe, one byte per pulse.
- fb_we  out  1  write request; held until accepted.
- fb_addr  out  ADDR_BITS  write address = y*H_RES + x; stable while fb_we=1.
- fb_data  out  COLOR_BITS  write pixel value; stable while fb_we=1.
- fb_ready  in  1  framebuffer accepts the write on a cycle where fb_we=1 and fb_ready=1.
- cmd_done  out  1  one-cycle pulse when a command's last write is accepted.
- cmd_err  out  1  one-cycle pulse on checksum, range, opcode or timeout error.
- overrun  out  1  one-cycle pulse when a byte arrives while in WRITE or FILL.

Behaviour:
- Packet format: 0xA5 (sync), CMD, X, Y, COLOR, CSUM. CSUM = CMD^X^Y^COLOR.
- Opcodes:
  - 0x01 = write pixel at (X,Y).
  - 0x02 = fill the whole screen with COLOR. X and Y are ignored by fill but are included in CSUM.
- Reset: all outputs 0, state IDLE, fb_addr=0, fb_data=0, timeout counter cleared. Reset overrides everything, including mid-packet and mid-fill; a pending fb_we drops in the cycle after reset is sampled.
- Byte states:
  - IDLE: on rx_valid with 0xA5, go to CMD. Any other byte is discarded silently with no flag.
  - CMD, X, Y, COLOR, CSUM: each rx_valid latches the byte and advances one state.
  - A second 0xA5 in a later state is treated as ordinary data; no resync.
- Timeout:
  - Counter clears on every accepted byte and on entry to CMD, and increments every cycle in states CMD..CSUM.
  - When it reaches TIMEOUT_CYCLES-1 without a byte: pulse cmd_err and return to IDLE.
  - If a byte arrives on that same cycle, the byte wins and the timeout does not fire.
- On the CSUM byte, checks are made in this priority order:
  - Checksum mismatch: cmd_err.
  - Opcode not 0x01/0x02: cmd_err.
  - Opcode 0x01 with X>=H_RES or Y>=V_RES: cmd_err.
  - On any error: pulse cmd_err the next cycle, go to IDLE, issue no write.
  - Otherwise: go to WRITE (0x01) or FILL (0x02).
- WRITE:
  - fb_we=1, fb_addr=Y*H_RES+X (computed at ADDR_BITS width), fb_data=COLOR[COLOR_BITS-1:0].
  - fb_we is asserted in the first cycle after the CSUM byte is accepted.
  - On a handshake (fb_we&fb_ready): next cycle fb_we=0, cmd_done=1, state IDLE.
- FILL:
  - fb_addr starts at 0 and fb_we=1 is held continuously.
  - Each handshake increments fb_addr by 1.
  - The handshake at fb_addr=H_RES*V_RES-1 ends the fill: fb_we=0, cmd_done pulses, state IDLE, fb_addr returns to 0.
  - With fb_ready tied high the fill takes exactly H_RES*V_RES cycles of fb_we=1.
- While in WRITE/FILL: any rx_valid pulses overrun for one cycle and the byte is dropped. The parser does not buffer bytes.
- Outputs are registered: cmd_done, cmd_err and overrun are never high for two consecutive cycles from a single event.
- fb_addr and fb_data must not change while fb_we=1 and fb_ready=0.

Test Plan:
- Pixel write: send A5 01 03 02 1C 1C with fb_ready=1 -> one fb_we pulse with fb_addr=323, fb_data=0x1C; cmd_done pulses one cycle later; cmd_err stays 0.
- Bad checksum: send A5 01 03 02 1C 1D -> cmd_err pulses once; fb_we never asserts; next valid packet is processed normally.
- Range and opcode errors: send A5 01 A0 00 FF 5E (X=160) -> cmd_err with no write. Send A5 07 00 00 00 07 -> cmd_err with no write.
- Fill with backpressure: send A5 02 00 00 E0 E2 with fb_ready toggling 1/0 -> exactly 19200 handshakes with addresses 0..19199 in order, all fb_data=0xE0; addr/data held during stalls; single cmd_done after the last handshake.
- Timeout and overrun: with TIMEOUT_CYCLES=100, send A5 01 then go idle -> cmd_err at 100 clocks, state IDLE. During a fill, inject a byte -> overrun pulses once and the fill completes unaffected.
- Reset mid-fill: assert reset at fill address 500 -> fb_we=0 and fb_addr=0 the next cycle; no cmd_done; a subsequent pixel packet works.
